// File: rtl/sm_sub_serial.sv
// rtl/sm_sub_serial.sv - bit-serial sign-magnitude subtractor (result = num1 - num2)
//
// Purpose:
//   Computes num1 - num2 on sign-magnitude operands one magnitude bit per
//   clock, LSB first. Same-sign-effective operands are added serially;
//   otherwise magnitudes are subtracted serially, and a final borrow
//   triggers a second serial pass that two's-complements the difference.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     operation request, sampled only in IDLE
//   num1      minuend   {sign, MAG_W-bit magnitude}, captured on accept
//   num2      subtrahend {sign, MAG_W-bit magnitude}, captured on accept
//   busy      high while an operation is in progress
//   done      one-cycle pulse; result/zeroflag valid from this cycle
//   result    {sign, (MAG_W+1)-bit magnitude}, registered
//   zeroflag  high when the result magnitude is zero, registered
//
// MAG_W must be at least 2.

module sm_sub_serial #(
  parameter int MAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAG_W:0]   num1,
  input  logic [MAG_W:0]   num2,
  output logic             busy,
  output logic             done,
  output logic [MAG_W+1:0] result,
  output logic             zeroflag
);

  localparam int CW = (MAG_W < 2) ? 1 : $clog2(MAG_W);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAG_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SERIAL,
    FIX,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic             s1;
  logic             s2e;
  logic [MAG_W-1:0] m1_sr;
  logic [MAG_W-1:0] m2_sr;
  logic [MAG_W-1:0] mag_lo;
  logic             mag_hi;
  logic             sign;
  logic             cb;
  logic [CW-1:0]    cnt;

  logic             add_mode;
  logic             bit_a;
  logic             bit_b;
  logic             bit_res;
  logic             add_cout;
  logic             sub_bout;
  logic             cb_nxt;
  logic             last_bit;
  logic             fix_bit;
  logic             fix_sum;
  logic             fix_carry;
  logic [MAG_W:0]   mag_full;
  logic             mag_zero;

  // Serial bit datapath: one full adder / full subtractor sharing the flop cb.
  always_comb begin
    add_mode  = (s1 == s2e);
    bit_a     = m1_sr[0];
    bit_b     = m2_sr[0];
    bit_res   = bit_a ^ bit_b ^ cb;
    add_cout  = (bit_a & bit_b) | (cb & (bit_a ^ bit_b));
    sub_bout  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & cb);
    cb_nxt    = add_mode ? add_cout : sub_bout;
    last_bit  = (cnt == LAST_CNT);
    // Two's-complement pass: invert each bit and ripple the +1 through cb.
    fix_bit   = ~mag_lo[0];
    fix_sum   = fix_bit ^ cb;
    fix_carry = fix_bit & cb;
    mag_full  = {mag_hi, mag_lo};
    mag_zero  = (mag_full == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SERIAL;
        end
      end
      SERIAL: begin
        if (last_bit) begin
          // A final borrow means |num1| < |num2|: the difference is negative.
          if (!add_mode && cb_nxt) begin
            state_nxt = FIX;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      FIX: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      s2e      <= 1'b0;
      m1_sr    <= '0;
      m2_sr    <= '0;
      mag_lo   <= '0;
      mag_hi   <= 1'b0;
      sign     <= 1'b0;
      cb       <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      result   <= '0;
      zeroflag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            s1     <= num1[MAG_W];
            // Subtraction is addition of the negated subtrahend.
            s2e    <= ~num2[MAG_W];
            m1_sr  <= num1[MAG_W-1:0];
            m2_sr  <= num2[MAG_W-1:0];
            mag_lo <= '0;
            mag_hi <= 1'b0;
            sign   <= 1'b0;
            cb     <= 1'b0;
            cnt    <= '0;
          end
        end
        SERIAL: begin
          mag_lo <= {bit_res, mag_lo[MAG_W-1:1]};
          m1_sr  <= m1_sr >> 1;
          m2_sr  <= m2_sr >> 1;
          cb     <= cb_nxt;
          if (last_bit) begin
            cnt <= '0;
            if (add_mode) begin
              mag_hi <= cb_nxt;
              sign   <= s1;
            end else if (!cb_nxt) begin
              mag_hi <= 1'b0;
              sign   <= s1;
            end else begin
              // Seed the +1 of the two's-complement pass.
              cb     <= 1'b1;
              mag_hi <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          mag_lo <= {fix_sum, mag_lo[MAG_W-1:1]};
          cb     <= fix_carry;
          if (last_bit) begin
            cnt    <= '0;
            mag_hi <= 1'b0;
            sign   <= s2e;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done     <= 1'b1;
          // No negative zero.
          result   <= {sign & ~mag_zero, mag_full};
          zeroflag <= mag_zero;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_sub_serial.sv
// tb/tb_sm_sub_serial.sv - self-checking bench for sm_sub_serial

module tb_sm_sub_serial;

  localparam int MW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [MW:0]   num1;
  logic [MW:0]   num2;
  logic          busy;
  logic          done;
  logic [MW+1:0] result;
  logic          zeroflag;

  int n_tests = 0;
  int n_fail  = 0;

  sm_sub_serial #(.MAG_W(MW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num1     (num1),
    .num2     (num2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zeroflag (zeroflag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: signed arithmetic on the operand values plus a
  // countdown to the done pulse derived from the latency rules.
  int            m_remaining = 0;
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [MW+1:0] m_res  = '0;
  logic          m_zf   = 1'b0;
  logic [MW+1:0] p_res  = '0;
  logic          p_zf   = 1'b0;

  function automatic int sm_val(input logic [MW:0] x);
    int mag;
    mag = int'(x[MW-1:0]);
    return x[MW] ? -mag : mag;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_remaining = 0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_res  = '0;
      m_zf   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_remaining == 0) begin
        if (start) begin
          int d;
          int amag;
          bit same_dir;
          d = sm_val(num1) - sm_val(num2);
          amag = (d < 0) ? -d : d;
          p_res = {(d < 0) ? 1'b1 : 1'b0, (MW+1)'(amag)};
          p_zf  = (amag == 0);
          same_dir = (num1[MW] != num2[MW]);
          if (same_dir || (num1[MW-1:0] >= num2[MW-1:0]))
            m_remaining = MW + 1;
          else
            m_remaining = 2 * MW + 1;
          m_busy = 1'b1;
        end
      end else begin
        m_remaining--;
        if (m_remaining == 0) begin
          m_done = 1'b1;
          m_busy = 1'b0;
          m_res  = p_res;
          m_zf   = p_zf;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    chk("result", int'(result), int'(m_res));
    chk("zeroflag", int'(zeroflag), int'(m_zf));
  end

  task automatic start_op(input logic [MW:0] n1, input logic [MW:0] n2);
    @(negedge clk);
    num1  = n1;
    num2  = n2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    num1  = (MW+1)'($urandom);
    num2  = (MW+1)'($urandom);
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = -1;
    ok  = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_op(input string nm, input logic [MW:0] n1, input logic [MW:0] n2,
                       input logic [MW+1:0] er, input logic ez, input int el);
    int lat;
    bit ok;
    start_op(n1, n2);
    wait_done(lat, ok);
    chk({nm, "_seen"}, int'(ok), 1);
    chk({nm, "_lat"}, lat, el);
    chk({nm, "_res"}, int'(result), int'(er));
    chk({nm, "_zf"}, int'(zeroflag), int'(ez));
  endtask

  initial begin
    int lat;
    bit ok;
    int pulses;

    rst   = 1'b1;
    start = 1'b0;
    num1  = '0;
    num2  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_zf", int'(zeroflag), 0);
    rst = 1'b0;

    do_op("p3_m_n2", 3'b011, 3'b110, 4'b0101, 1'b0, 3);
    do_op("p1_m_p3", 3'b001, 3'b011, 4'b1010, 1'b0, 5);
    do_op("n2_m_n2", 3'b110, 3'b110, 4'b0000, 1'b1, 3);
    do_op("n0_m_p0", 3'b100, 3'b000, 4'b0000, 1'b1, 3);
    do_op("p3_m_n3", 3'b011, 3'b111, 4'b0110, 1'b0, 3);
    do_op("n1_m_p3", 3'b101, 3'b011, 4'b1100, 1'b0, 3);
    do_op("p0_m_p3", 3'b000, 3'b011, 4'b1011, 1'b0, 5);
    do_op("p3_m_p1", 3'b011, 3'b001, 4'b0010, 1'b0, 3);

    // Start while busy is ignored.
    start_op(3'b011, 3'b110);
    @(negedge clk);
    num1  = 3'b001;
    num2  = 3'b011;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("busy_start_pulses", pulses, 1);
    chk("busy_start_res", int'(result), 32'h5);

    // Start held high through DONE: accepted in the following IDLE cycle.
    @(negedge clk);
    num1  = 3'b001;
    num2  = 3'b011;
    start = 1'b1;
    wait_done(lat, ok);
    chk("hold_first_seen", int'(ok), 1);
    chk("hold_first_res", int'(result), 32'ha);
    num1 = 3'b011;
    num2 = 3'b110;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("hold_second_busy", int'(busy), 1);
    wait_done(lat, ok);
    chk("hold_second_seen", int'(ok), 1);
    chk("hold_second_lat", lat, 2);
    chk("hold_second_res", int'(result), 32'h5);

    // Reset asserted at edge 2 of a borrow-path operation.
    start_op(3'b001, 3'b011);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_zf", int'(zeroflag), 0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    do_op("after_abort", 3'b001, 3'b011, 4'b1010, 1'b0, 5);

    // Every operand pair, checked by the model.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        start_op((MW+1)'(i), (MW+1)'(j));
        wait_done(lat, ok);
        chk("sweep_seen", int'(ok), 1);
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
